// File: rtl/pl_reg_mw_elastic_if.sv
// rtl/pl_reg_mw_elastic_if.sv - MEM->WB elastic stage handshake and bundle signals
interface pl_reg_mw_elastic_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic                     reg_write_m;
  logic [1:0]               result_src_m;
  logic [DATA_WIDTH-1:0]    alu_result_m;
  logic [DATA_WIDTH-1:0]    read_data_m;
  logic [4:0]               rd_m;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_m;
  logic                     out_valid;
  logic                     out_ready;
  logic                     reg_write_w;
  logic [1:0]               result_src_w;
  logic [DATA_WIDTH-1:0]    alu_result_w;
  logic [DATA_WIDTH-1:0]    read_data_w;
  logic [4:0]               rd_w;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_w;
  logic [1:0]               count;

  modport master (
    output flush, in_valid, reg_write_m, result_src_m, alu_result_m, read_data_m,
           rd_m, pc_plus4_m, out_ready,
    input  in_ready, out_valid, reg_write_w, result_src_w, alu_result_w, read_data_w,
           rd_w, pc_plus4_w, count
  );

  modport slave (
    input  flush, in_valid, reg_write_m, result_src_m, alu_result_m, read_data_m,
           rd_m, pc_plus4_m, out_ready,
    output in_ready, out_valid, reg_write_w, result_src_w, alu_result_w, read_data_w,
           rd_w, pc_plus4_w, count
  );
endinterface

// File: rtl/pl_reg_mw_elastic.sv
// rtl/pl_reg_mw_elastic.sv - elastic MEM->WB pipeline register with optional skid entry
module pl_reg_mw_elastic #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SKID          = 1
) (
  input logic                 clk,
  input logic                 rst,
  pl_reg_mw_elastic_if.slave  bus
);
  typedef struct packed {
    logic                     reg_write;
    logic [1:0]               result_src;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic [DATA_WIDTH-1:0]    read_data;
    logic [4:0]               rd;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
  } bundle_t;

  bundle_t in_bundle;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  logic    main_valid_q, main_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    in_ready;
  logic    accept;
  logic    pop;

  assign in_bundle = {bus.reg_write_m, bus.result_src_m, bus.alu_result_m,
                      bus.read_data_m, bus.rd_m, bus.pc_plus4_m};

  // With a skid entry, ready comes straight from a flop so W never reaches back into M.
  assign in_ready = (SKID != 0) ? !skid_valid_q : (!main_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign pop      = main_valid_q & bus.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      main_d       = '0;
      skid_d       = '0;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SKID != 0) begin
      if (skid_valid_q) begin
        if (pop) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end
      end else if (!main_valid_q) begin
        if (accept) begin
          main_d       = in_bundle;
          main_valid_d = 1'b1;
        end
      end else if (pop) begin
        if (accept) begin
          main_d = in_bundle;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d       = in_bundle;
        skid_valid_d = 1'b1;
      end
    end else begin
      if (accept) begin
        main_d       = in_bundle;
        main_valid_d = 1'b1;
      end else if (pop) begin
        main_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = main_valid_q;
  // An empty stage must never request a register write, whatever the payload holds.
  assign bus.reg_write_w  = main_valid_q & main_q.reg_write;
  assign bus.result_src_w = main_q.result_src;
  assign bus.alu_result_w = main_q.alu_result;
  assign bus.read_data_w  = main_q.read_data;
  assign bus.rd_w         = main_q.rd;
  assign bus.pc_plus4_w   = main_q.pc_plus4;
  assign bus.count        = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
endmodule

// File: tb/tb_pl_reg_mw_elastic.sv
// tb/tb_pl_reg_mw_elastic.sv - self-checking bench for pl_reg_mw_elastic, both SKID modes
module tb_pl_reg_mw_elastic;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pl_reg_mw_elastic_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) b1 ();
  pl_reg_mw_elastic_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) b0 ();

  pl_reg_mw_elastic #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SKID(1)) dut_skid (
    .clk(clk), .rst(rst), .bus(b1)
  );
  pl_reg_mw_elastic #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SKID(0)) dut_noskid (
    .clk(clk), .rst(rst), .bus(b0)
  );

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [4:0]  rd;
    logic [31:0] pc;
  } bnd_t;

  bnd_t q[$];
  bnd_t last;
  int   compared   = 0;
  int   mismatched = 0;
  int   cur        = 1;
  logic acc_l;

  function automatic bnd_t mk(input logic [4:0] rd, input logic rw);
    bnd_t b;
    b.rw   = rw;
    b.rs   = 2'($urandom);
    b.alu  = $urandom;
    b.rdat = $urandom;
    b.rd   = rd;
    b.pc   = $urandom;
    return b;
  endfunction

  function automatic logic model_ready(input logic ordy);
    if (cur == 1) return q.size() < 2;
    return (q.size() == 0) || ordy;
  endfunction

  task automatic drive(input logic fl, input logic iv, input bnd_t b, input logic ordy);
    if (cur == 1) begin
      b1.flush = fl; b1.in_valid = iv; b1.out_ready = ordy;
      b1.reg_write_m = b.rw; b1.result_src_m = b.rs; b1.alu_result_m = b.alu;
      b1.read_data_m = b.rdat; b1.rd_m = b.rd; b1.pc_plus4_m = b.pc;
    end else begin
      b0.flush = fl; b0.in_valid = iv; b0.out_ready = ordy;
      b0.reg_write_m = b.rw; b0.result_src_m = b.rs; b0.alu_result_m = b.alu;
      b0.read_data_m = b.rdat; b0.rd_m = b.rd; b0.pc_plus4_m = b.pc;
    end
  endtask

  task automatic chk(input logic ordy, input string tag);
    logic         o_ir, o_ov, o_rw, e_ir, e_ov, e_rw;
    logic [1:0]   o_cnt, e_cnt;
    logic [102:0] o_pl, e_pl;
    bnd_t         e;
    if (cur == 1) begin
      o_ir = b1.in_ready; o_ov = b1.out_valid; o_rw = b1.reg_write_w; o_cnt = b1.count;
      o_pl = {b1.result_src_w, b1.alu_result_w, b1.read_data_w, b1.rd_w, b1.pc_plus4_w};
    end else begin
      o_ir = b0.in_ready; o_ov = b0.out_valid; o_rw = b0.reg_write_w; o_cnt = b0.count;
      o_pl = {b0.result_src_w, b0.alu_result_w, b0.read_data_w, b0.rd_w, b0.pc_plus4_w};
    end
    e     = (q.size() > 0) ? q[0] : last;
    e_ir  = model_ready(ordy);
    e_ov  = q.size() > 0;
    e_rw  = e_ov & e.rw;
    e_cnt = 2'(q.size());
    e_pl  = {e.rs, e.alu, e.rdat, e.rd, e.pc};
    compared++;
    assert (o_ir === e_ir) else begin
      mismatched++;
      $error("FAIL %s skid=%0d in_ready: observed %0b expected %0b", tag, cur, o_ir, e_ir);
    end
    compared++;
    assert (o_ov === e_ov) else begin
      mismatched++;
      $error("FAIL %s skid=%0d out_valid: observed %0b expected %0b", tag, cur, o_ov, e_ov);
    end
    compared++;
    assert (o_rw === e_rw) else begin
      mismatched++;
      $error("FAIL %s skid=%0d reg_write_w: observed %0b expected %0b", tag, cur, o_rw, e_rw);
    end
    compared++;
    assert (o_cnt === e_cnt) else begin
      mismatched++;
      $error("FAIL %s skid=%0d count: observed %0d expected %0d", tag, cur, o_cnt, e_cnt);
    end
    compared++;
    assert (o_pl === e_pl) else begin
      mismatched++;
      $error("FAIL %s skid=%0d payload: observed %h expected %h", tag, cur, o_pl, e_pl);
    end
  endtask

  // One cycle: drive at negedge, check settled outputs, then apply queue semantics at the edge.
  task automatic step(input logic fl, input logic iv, input bnd_t b, input logic ordy,
                      input string tag, output logic acc);
    logic pop;
    drive(fl, iv, b, ordy);
    #1;
    chk(ordy, tag);
    acc = iv && !fl && model_ready(ordy);
    pop = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
      last = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(b);
      if (q.size() > 0) last = q[0];
    end
    @(negedge clk);
  endtask

  task automatic reset_all();
    drive(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    q.delete();
    last = '0;
    @(negedge clk);
    chk(1'b0, "reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic random_phase(input int n);
    bnd_t pend;
    logic have, fl, iv, ordy;
    have = 1'b0;
    pend = '0;
    for (int i = 0; i < n; i++) begin
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 3) != 0) || have;
      ordy = ($urandom_range(0, 3) != 0);
      if (!have) pend = mk(5'($urandom), 1'($urandom));
      step(fl, iv, pend, ordy, "random", acc_l);
      have = iv && !acc_l && !fl;
    end
  endtask

  bnd_t bb5, bb6, bb7;

  initial begin
    last = '0;
    cur = 0; drive(1'b0, 1'b0, '0, 1'b0);
    cur = 1; drive(1'b0, 1'b0, '0, 1'b0);
    reset_all();

    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, mk(5'(i), 1'b1), 1'b1, "stream", acc_l);
    step(1'b0, 1'b0, '0, 1'b1, "stream_tail", acc_l);
    step(1'b0, 1'b0, '0, 1'b1, "stream_idle", acc_l);

    bb5 = mk(5'd5, 1'b1); bb6 = mk(5'd6, 1'b0); bb7 = mk(5'd7, 1'b1);
    step(1'b0, 1'b1, bb5, 1'b0, "bp_fill5", acc_l);
    step(1'b0, 1'b1, bb6, 1'b0, "bp_fill6", acc_l);
    step(1'b0, 1'b1, bb7, 1'b0, "bp_hold7", acc_l);
    step(1'b0, 1'b1, bb7, 1'b0, "bp_hold7b", acc_l);
    step(1'b0, 1'b1, bb7, 1'b1, "bp_drain5", acc_l);
    step(1'b0, 1'b1, bb7, 1'b1, "bp_drain6", acc_l);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, "bp_drain", acc_l);

    step(1'b0, 1'b1, mk(5'd10, 1'b1), 1'b0, "fl_fill", acc_l);
    step(1'b0, 1'b1, mk(5'd11, 1'b1), 1'b0, "fl_fill", acc_l);
    step(1'b1, 1'b1, mk(5'd9, 1'b1), 1'b0, "fl_collide", acc_l);
    step(1'b0, 1'b0, '0, 1'b1, "fl_after", acc_l);
    step(1'b0, 1'b0, '0, 1'b1, "fl_after2", acc_l);

    step(1'b0, 1'b1, mk(5'd3, 1'b1), 1'b1, "gate_accept", acc_l);
    step(1'b0, 1'b0, '0, 1'b1, "gate_pop", acc_l);
    step(1'b0, 1'b0, '0, 1'b1, "gate_idle", acc_l);

    step(1'b0, 1'b1, mk(5'd12, 1'b1), 1'b0, "ar_fill", acc_l);
    step(1'b0, 1'b1, mk(5'd13, 1'b1), 1'b0, "ar_fill", acc_l);
    drive(1'b0, 1'b0, '0, 1'b0);
    #2;
    rst = 1'b1;
    q.delete();
    last = '0;
    #1;
    chk(1'b0, "async_reset");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, mk(5'd14, 1'b1), 1'b1, "post_reset", acc_l);
    step(1'b0, 1'b0, '0, 1'b1, "post_reset2", acc_l);

    random_phase(300);

    cur = 0;
    reset_all();
    bb5 = mk(5'd1, 1'b1); bb6 = mk(5'd2, 1'b1);
    step(1'b0, 1'b1, bb5, 1'b0, "ns_fill", acc_l);
    step(1'b0, 1'b1, bb6, 1'b0, "ns_block", acc_l);
    step(1'b0, 1'b1, bb6, 1'b1, "ns_swap", acc_l);
    for (int i = 3; i <= 6; i++) step(1'b0, 1'b1, mk(5'(i), 1'b1), 1'b1, "ns_stream", acc_l);
    step(1'b0, 1'b0, '0, 1'b1, "ns_drain", acc_l);
    step(1'b0, 1'b0, '0, 1'b1, "ns_idle", acc_l);
    step(1'b0, 1'b1, mk(5'd8, 1'b1), 1'b0, "ns_fl_fill", acc_l);
    step(1'b1, 1'b1, mk(5'd9, 1'b1), 1'b1, "ns_fl_collide", acc_l);
    step(1'b0, 1'b0, '0, 1'b1, "ns_fl_after", acc_l);

    random_phase(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pl_reg_mw_elastic.md
# pl_reg_mw_elastic

Parametrised elastic MEM→WB pipeline register, successor to the fixed stall/clear stage register. It carries the writeback bundle (reg_write, result_src, alu_result, read_data, rd, pc_plus4) under a valid/ready handshake instead of a global enable. An optional skid entry gives full throughput with no combinational ready path from W back to M. Flush squashes all in-flight entries, and an empty stage never presents an asserted register write.

## Interface
- ADDRESS_WIDTH, 32, width of pc_plus4 fields
- DATA_WIDTH, 32, width of alu_result / read_data fields
- SKID, 1, 1 = two-entry (main + skid) buffer with registered in_ready; 0 = single entry with combinational in_ready
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all entries
- in_valid  in  1  M-side bundle valid
- in_ready  out  1  stage can accept this cycle
- reg_write_m, result_src_m[1:0], alu_result_m[DATA_WIDTH], read_data_m[DATA_WIDTH], rd_m[5], pc_plus4_m[ADDRESS_WIDTH]  in  M-side bundle
- out_valid  out  1  W-side bundle valid
- out_ready  in  1  W-side consumes this cycle
- reg_write_w, result_src_w[1:0], alu_result_w, read_data_w, rd_w[5], pc_plus4_w  out  W-side bundle (main entry)
- count  out  2  occupancy, 0..2 (0..1 when SKID=0)

## Operation
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Main entry drives the W outputs. out_valid = main_valid.
- reg_write_w = main_valid & main.reg_write, so a write is never signalled while the stage is empty.
- SKID=1, in_ready = !skid_valid (registered). Update cases:
  - main empty, accept: bundle → main.
  - main full, pop, skid empty: on accept, bundle → main; otherwise main becomes empty.
  - main full, no pop, accept: bundle → skid.
  - skid full, pop: skid → main, skid empties. No accept is possible because in_ready=0.
  - skid full, no pop: hold everything.
- SKID=0, in_ready = !main_valid | out_ready (combinational). On accept, bundle → main. On pop without accept, main empties.
- Entries leave in arrival order. No bundle is dropped or duplicated.
- Flush has priority over accept and pop in the same cycle. All valids clear and the incoming bundle is discarded.
- Payload registers reset and flush to 0. They hold their value while the entry is invalid, apart from the bundle overwrites above.
- count = main_valid + skid_valid.

## Timing
- Latency is 1 cycle: a bundle accepted at edge N appears on the W outputs with out_valid=1 after edge N.
- Throughput is one bundle per cycle with out_ready held high, for both SKID values.
- SKID=1: in_ready falls the cycle after the skid fills and rises the cycle after the skid drains.
- Reset values, immediate on rst assertion: out_valid=0, reg_write_w=0, result_src_w=0, alu_result_w=0, read_data_w=0, rd_w=0, pc_plus4_w=0, count=0, skid empty.
  - in_ready=1 during and after reset in both modes.
- Reset mid-transfer discards all entries. The first accept after deassertion behaves as a fresh start.
- After flush at edge N: out_valid=0, count=0, in_ready=1 after edge N. A new accept is legal in the cycle following N.

## Test plan
- Reset: assert rst asynchronously mid-cycle with 2 entries held → all outputs 0 and count=0 without waiting for a clock edge; in_ready=1 after release.
- Streaming, SKID=1, out_ready=1: send rd=1..4 back-to-back → rd_w=1..4 on consecutive cycles, each 1 cycle after its accept; in_ready stays 1; count stays ≤1.
- Backpressure, SKID=1, out_ready=0: offer rd=5,6,7 → 5 and 6 accepted, count=2, in_ready=0, 7 held on the M side. Raise out_ready → W sees 5, 6, 7 in order, with no gaps once draining starts.
- Flush collision: count=2 and flush=1 with in_valid=1 (rd=9) in the same cycle → next cycle out_valid=0, reg_write_w=0, count=0; rd=9 never appears on W.
- Empty gating: accept a bundle with reg_write_m=1 and pop it, then idle → reg_write_w=0 while out_valid=0, even though the payload registers retain the old data.
- SKID=0: out_ready=0 with one entry → in_ready=0. Raise out_ready with in_valid=1 → pop and accept happen in the same cycle; throughput is 1/cycle and count never exceeds 1.
